// File: rtl/clk_pixel_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_pixel_gen_pkg
// Purpose  : Shared VGA definitions: 640x480 timing constants, the default
//            pixel-clock divide ratio, and a helper for the divider duty term.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_pixel_gen_pkg;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int H_PW    = 96;
  localparam int H_BP    = 48;
  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_TOTAL = H_PW + H_BP + H_DISP + H_FP;

  // 640x480 @ 60 Hz vertical timing, in lines
  localparam int V_PW    = 2;
  localparam int V_BP    = 33;
  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_TOTAL = V_PW + V_BP + V_DISP + V_FP;

  // 100 MHz system clock / 4 = 25 MHz pixel clock
  localparam int PIX_DIV          = 4;
  localparam int PIX_LOCK_DEFAULT = 16;

  // Number of phase-counter states for which the posedge duty term is high.
  // For even ratios this is exactly half the period; for odd ratios it is
  // the rounded-up half, trimmed by half a cycle with the falling-edge term.
  function automatic int p_high_len(input int div);
    return (div + 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_pixel_gen_reset_sync.sv
`default_nettype none
// ============================================================================
// Module   : reset_sync
// Purpose  : Two-flop active-low reset synchronizer. Assertion propagates
//            asynchronously; deassertion reaches the output on the second
//            rising clk edge after rst_n rises.
// Ports    : clk        in  system clock
//            rst_n      in  raw asynchronous active-low reset
//            rst_sync_n out synchronized active-low reset
// Revision : 1.0 - initial release
// ============================================================================
module reset_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  assign rst_sync_n = sync[1];

endmodule
`default_nettype wire

// File: rtl/clk_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_pixel_gen
// Purpose  : Integer clock divider producing a 50%-duty pixel clock, a
//            one-cycle clk-domain pixel strobe and a lock flag.
// Ports    : clk       in  system clock
//            rst_n     in  asynchronous active-low reset
//            clk_pixel out clk/DIV, 50% duty (half-cycle resolution for odd DIV)
//            pix_ce    out one clk cycle high per pixel period, aligned with
//                          the clk edge that raises clk_pixel
//            locked    out high after LOCK_CYCLES full output periods
// Revision : 1.0 - initial release
// ============================================================================
module clk_pixel_gen
  import clk_pixel_gen_pkg::*;
#(
  parameter int DIV         = PIX_DIV,          // >= 2, odd or even
  parameter int LOCK_CYCLES = PIX_LOCK_DEFAULT  // >= 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_pixel,
  output logic pix_ce,
  output logic locked
);

  localparam int CW = $clog2(DIV);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] P_HIGH   = CW'(p_high_len(DIV));
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic          rst_int_n;
  logic [CW-1:0] cnt;
  logic          wrap;
  logic          p_term;
  logic [LW-1:0] lock_cnt;

  // The synchronizer output is the reset for every flop below, so a low
  // rst_n clears the whole block immediately while release is clean.
  reset_sync u_reset_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_sync_n (rst_int_n)
  );

  assign wrap = (cnt == CNT_MAX);

  // Phase counter, posedge duty term and strobe. p_term and pix_ce are
  // computed from the pre-increment count, so the first update after
  // release (cnt == 0) raises both on the same edge.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cnt    <= '0;
      p_term <= 1'b0;
      pix_ce <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + CW'(1);
      p_term <= (cnt < P_HIGH);
      pix_ce <= (cnt == '0);
    end
  end

  // Lock: count wraps up to LOCK_MAX, then latch locked one cycle later.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (wrap && (lock_cnt != LOCK_MAX)) begin
        lock_cnt <= lock_cnt + LW'(1);
      end
      if (lock_cnt == LOCK_MAX) begin
        locked <= 1'b1;
      end
    end
  end

  if ((DIV % 2) == 0) begin : g_even
    // Even ratio: the posedge term is already exactly 50% duty.
    assign clk_pixel = p_term;
  end else begin : g_odd
    // Odd ratio: the posedge term is high for (DIV+1)/2 cycles. ANDing with
    // a copy delayed by half a cycle delays the rising edge by half a
    // cycle while keeping the falling edge, leaving DIV/2 cycles high.
    logic n_term;

    always_ff @(negedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
        n_term <= 1'b0;
      end else begin
        n_term <= p_term;
      end
    end

    assign clk_pixel = p_term & n_term;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_pixel_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_pixel_gen
// Purpose  : Self-checking bench for clk_pixel_gen with DIV = 4, 3 and 2
//            instances sharing one clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_pixel_gen;

  localparam int WIN      = 80;     // cycles observed after each release
  localparam int LONG_CYC = 40008;  // multiple of 4, 3 and 2

  typedef struct {
    int dut;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;

  logic pix_d4, ce_d4, lk_d4;
  logic pix_d3, ce_d3, lk_d3;
  logic pix_d2, ce_d2, lk_d2;

  logic [2:0] pix_v;
  logic [2:0] ce_v;
  logic [2:0] lk_v;

  assign pix_v = {pix_d2, pix_d3, pix_d4};
  assign ce_v  = {ce_d2, ce_d3, ce_d4};
  assign lk_v  = {lk_d2, lk_d3, lk_d4};

  int   n_checks;
  int   n_fail;
  ev_t  sb[$];

  clk_pixel_gen #(.DIV(4), .LOCK_CYCLES(16)) u_div4 (
    .clk(clk), .rst_n(rst_n), .clk_pixel(pix_d4), .pix_ce(ce_d4), .locked(lk_d4)
  );
  clk_pixel_gen #(.DIV(3), .LOCK_CYCLES(5)) u_div3 (
    .clk(clk), .rst_n(rst_n), .clk_pixel(pix_d3), .pix_ce(ce_d3), .locked(lk_d3)
  );
  clk_pixel_gen #(.DIV(2), .LOCK_CYCLES(4)) u_div2 (
    .clk(clk), .rst_n(rst_n), .clk_pixel(pix_d2), .pix_ce(ce_d2), .locked(lk_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int d);
    case (d)
      0:       return 4;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int lock_of(input int d);
    case (d)
      0:       return 16;
      1:       return 5;
      default: return 4;
    endcase
  endfunction

  // Rising clk edge (counted from rst_n release) after which locked is high:
  // 2 synchronizer edges + LOCK_CYCLES*DIV + 1.
  function automatic int lock_edge(input int d);
    return 2 + lock_of(d) * div_of(d) + 1;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (pix_v[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s clk_pixel dut%0d: got %b expected 0", tag, d, pix_v[d]);
      end
      n_checks++;
      if (ce_v[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s pix_ce dut%0d: got %b expected 0", tag, d, ce_v[d]);
      end
      n_checks++;
      if (lk_v[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s locked dut%0d: got %b expected 0", tag, d, lk_v[d]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
  endtask

  // Release reset and track strobe schedule, first edge and lock timing.
  task automatic test_release(input string tag);
    ev_t e;
    ev_t got;
    logic exp_b;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      for (int d = 0; d < 3; d++) begin
        if (c >= 3 && ((c - 3) % div_of(d)) == 0) begin
          e.dut = d;
          e.cyc = c;
          sb.push_back(e);
        end
      end
    end
    for (int c = 1; c <= WIN; c++) begin
      @(posedge clk);
      #1;
      if (c == 2 || c == 3) begin
        exp_b = (c == 3);
        n_checks++;
        if (pix_d4 !== exp_b) begin
          n_fail++;
          $display("FAIL %s first_edge div4 edge%0d: got %b expected %b", tag, c, pix_d4, exp_b);
        end
        n_checks++;
        if (pix_d2 !== exp_b) begin
          n_fail++;
          $display("FAIL %s first_edge div2 edge%0d: got %b expected %b", tag, c, pix_d2, exp_b);
        end
      end
      for (int d = 0; d < 3; d++) begin
        if (ce_v[d] === 1'b1) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s pix_ce dut%0d: unexpected pulse at edge %0d, none expected", tag, d, c);
          end else begin
            got = sb.pop_front();
            if (got.dut != d || got.cyc != c) begin
              n_fail++;
              $display("FAIL %s pix_ce: got dut%0d at edge %0d expected dut%0d at edge %0d",
                       tag, d, c, got.dut, got.cyc);
            end
          end
        end
        exp_b = (c >= lock_edge(d));
        n_checks++;
        if (lk_v[d] !== exp_b) begin
          n_fail++;
          $display("FAIL %s locked dut%0d edge%0d: got %b expected %b", tag, d, c, lk_v[d], exp_b);
        end
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s pix_ce missing: got %0d pulses outstanding expected 0", tag, sb.size());
    end
  endtask

  // Long run sampled every half clk: periods, high times and pulse counts.
  task automatic test_long_run;
    int   rises[3];
    int   ces[3];
    int   last_rise[3];
    logic prev_p[3];
    logic prev_c[3];
    for (int d = 0; d < 3; d++) begin
      rises[d]     = 0;
      ces[d]       = 0;
      last_rise[d] = -1;
      prev_p[d]    = pix_v[d];
      prev_c[d]    = ce_v[d];
    end
    for (int h = 1; h <= 2 * LONG_CYC; h++) begin
      @(clk);
      #1;
      for (int d = 0; d < 3; d++) begin
        if (ce_v[d] === 1'b1 && prev_c[d] === 1'b0) ces[d]++;
        if (pix_v[d] === 1'b1 && prev_p[d] === 1'b0) begin
          if (last_rise[d] >= 0) begin
            n_checks++;
            if (h - last_rise[d] != 2 * div_of(d)) begin
              n_fail++;
              $display("FAIL long period dut%0d: got %0d half-cycles expected %0d",
                       d, h - last_rise[d], 2 * div_of(d));
            end
          end
          last_rise[d] = h;
          rises[d]++;
        end
        if (pix_v[d] === 1'b0 && prev_p[d] === 1'b1 && last_rise[d] >= 0) begin
          n_checks++;
          if (h - last_rise[d] != div_of(d)) begin
            n_fail++;
            $display("FAIL long high_time dut%0d: got %0d half-cycles expected %0d",
                     d, h - last_rise[d], div_of(d));
          end
        end
        prev_p[d] = pix_v[d];
        prev_c[d] = ce_v[d];
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (rises[d] != LONG_CYC / div_of(d)) begin
        n_fail++;
        $display("FAIL long rises dut%0d: got %0d expected %0d", d, rises[d], LONG_CYC / div_of(d));
      end
      n_checks++;
      if (ces[d] != rises[d]) begin
        n_fail++;
        $display("FAIL long ce_vs_rises dut%0d: got %0d pulses expected %0d", d, ces[d], rises[d]);
      end
      n_checks++;
      if (lk_v[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL long locked dut%0d: got %b expected 1", d, lk_v[d]);
      end
    end
  endtask

  // Drop rst_n mid-cycle while the DIV=4 clock is high.
  task automatic test_async_reset;
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (pix_d4 !== 1'b1 && guard < 20);
    n_checks++;
    if (pix_d4 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup clk_pixel div4: got %b expected 1 within 20 cycles", pix_d4);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("async_hold");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    test_reset();
    test_release("release");
    test_long_run();
    test_async_reset();
    test_release("relock");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
